// File: rtl/bram_responder.sv
// bram_responder: block-RAM responder for the 16-bit adr/req/ack memory port, with programmable wait states.
// Optional feature: define BRAM_RESPONDER_RANGE_CHECK_EN to add a_err and block out-of-range accesses.
module bram_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] a_adr,
    input  logic        a_req,
    output logic        a_ack,
    input  logic        a_write,
    input  logic [1:0]  a_sel,
    input  logic [15:0] a_wdata,
    output logic [15:0] a_rdata
`ifdef BRAM_RESPONDER_RANGE_CHECK_EN
    ,
    output logic        a_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state_reg;
    logic [3:0]    wcnt_reg;
    logic [17:0]   adr_reg;
    logic          write_reg;
    logic [1:0]    sel_reg;
    logic [15:0]   wdata_reg;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          oor;
    logic          access;
    logic [1:0]    lane_we;
    logic [15:0]   rd_word;

    assign idx = adr_reg[AW-1:0];

`ifdef BRAM_RESPONDER_RANGE_CHECK_EN
    logic err_reg;
    assign a_err = err_reg;

    generate
        if (AW < 18) begin : g_oor
            assign oor = |adr_reg[17:AW];
        end else begin : g_full_range
            assign oor = 1'b0;
        end
    endgenerate
`else
    assign oor = 1'b0;
`endif

    // Upper address bits only matter for range checking; otherwise accesses alias.
    logic unused_adr_hi;
    assign unused_adr_hi = ^adr_reg;

    // DONE is the commit cycle: the RAM access and the ack register load
    // both happen on the edge that closes it, so ack/rdata appear together.
    assign access = (state_reg == ST_DONE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_we[gi] = access & write_reg & sel_reg[gi] & ~oor;
        end
    endgenerate

    assign rd_word = oor ? 16'hDEAD : mem[idx];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (lane_we[i]) begin
                mem[idx][i*8 +: 8] <= wdata_reg[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            wcnt_reg  <= 4'd0;
            adr_reg   <= 18'd0;
            write_reg <= 1'b0;
            sel_reg   <= 2'b00;
            wdata_reg <= 16'h0000;
            a_ack     <= 1'b0;
            a_rdata   <= 16'h0000;
`ifdef BRAM_RESPONDER_RANGE_CHECK_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            a_ack <= 1'b0;
`ifdef BRAM_RESPONDER_RANGE_CHECK_EN
            err_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (a_req) begin
                        adr_reg   <= a_adr;
                        write_reg <= a_write;
                        sel_reg   <= a_sel;
                        wdata_reg <= a_wdata;
                        if (WAIT_STATES == 0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            wcnt_reg  <= 4'(WAIT_STATES - 1);
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt_reg == 4'd0) begin
                        state_reg <= ST_DONE;
                    end else begin
                        wcnt_reg <= wcnt_reg - 4'd1;
                    end
                end
                ST_DONE: begin
                    a_ack <= 1'b1;
                    if (!write_reg) begin
                        a_rdata <= rd_word;
                    end
`ifdef BRAM_RESPONDER_RANGE_CHECK_EN
                    err_reg <= oor;
`endif
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
